// File: rtl/mod16_count_ctrl_if.sv
// mod16_count_ctrl_if: command handshake and counter status bundle for the
// mod16_count_ctrl sequencing controller.
//   master modport: host side (drives command, abort, hold)
//   slave  modport: controller side (drives count and status)
interface mod16_count_ctrl_if #(
    parameter int CW = 4,
    parameter int PW = 4
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [CW-1:0] cmd_term;
    logic [PW-1:0] cmd_passes;
    logic          abort;
    logic          hold;
    logic [CW-1:0] count;
    logic          wrap;
    logic          done;
    logic          busy;
    logic [PW-1:0] passes_left;

    modport master (
        output cmd_valid, cmd_term, cmd_passes, abort, hold,
        input  cmd_ready, count, wrap, done, busy, passes_left
    );

    modport slave (
        input  cmd_valid, cmd_term, cmd_passes, abort, hold,
        output cmd_ready, count, wrap, done, busy, passes_left
    );
endinterface

// File: rtl/mod16_count_ctrl.sv
// mod16_count_ctrl: runs a CW-bit counter as a modulo-(term+1) counter for a
// commanded number of passes, with wrap/done pulses and abort.
// Optional feature macro: MOD16_CTRL_HOLD_EN (enables the HOLD state; when
// undefined the hold input is ignored and RUN never pauses).
// All outputs are registered; reset is synchronous and active-low.
module mod16_count_ctrl #(
    parameter int CW = 4,
    parameter int PW = 4
) (
    input  logic              clk,
    input  logic              reset,
    mod16_count_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] PASS_ONE = {{(PW-1){1'b0}}, 1'b1};

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_term;
    logic [CW-1:0] w_term_nxt;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;
    logic [PW-1:0] r_passes_left;
    logic [PW-1:0] w_passes_nxt;
    logic          r_wrap;
    logic          w_wrap_nxt;
    logic          r_done;
    logic          w_done_nxt;
    logic          r_busy;
    logic          w_busy_nxt;
    logic          r_cmd_ready;
    logic          w_cmd_ready_nxt;
    logic          w_step;
    logic          w_hold;

`ifdef MOD16_CTRL_HOLD_EN
    assign w_hold = bus.hold;
`else
    logic w_unused_hold;
    assign w_unused_hold = bus.hold;
    assign w_hold        = 1'b0;
`endif

    // Next-state and next-output logic; w_step marks an edge that advances the count.
    always_comb begin
        w_state_nxt  = r_state;
        w_term_nxt   = r_term;
        w_count_nxt  = r_count;
        w_passes_nxt = r_passes_left;
        w_wrap_nxt   = 1'b0;
        w_done_nxt   = 1'b0;
        w_step       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.cmd_valid && r_cmd_ready) begin
                    w_term_nxt   = bus.cmd_term;
                    w_count_nxt  = '0;
                    w_passes_nxt = bus.cmd_passes;
                    if (bus.cmd_passes != '0) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (bus.abort) begin
                    w_state_nxt  = ST_IDLE;
                    w_count_nxt  = '0;
                    w_passes_nxt = '0;
                end else if (w_hold) begin
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_step = 1'b1;
                end
            end
`ifdef MOD16_CTRL_HOLD_EN
            ST_HOLD: begin
                // Releasing hold counts on the same edge, so each held cycle
                // adds exactly one cycle to the run.
                if (bus.abort) begin
                    w_state_nxt  = ST_IDLE;
                    w_count_nxt  = '0;
                    w_passes_nxt = '0;
                end else if (w_hold) begin
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_step = 1'b1;
                end
            end
`endif
            ST_DONE: begin
                // Entered with done already high after the last wrap; a
                // zero-pass command enters with done low and raises it here.
                if (r_done) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_count_nxt  = '0;
                w_passes_nxt = '0;
            end
        endcase

        if (w_step) begin
            if (r_count == r_term) begin
                w_count_nxt = '0;
                w_wrap_nxt  = 1'b1;
                if (r_passes_left != '0) begin
                    w_passes_nxt = r_passes_left - PASS_ONE;
                end else begin
                    w_passes_nxt = '0;
                end
                if (r_passes_left <= PASS_ONE) begin
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end else begin
                w_count_nxt = r_count + CNT_ONE;
                w_state_nxt = ST_RUN;
            end
        end else begin
            w_wrap_nxt = w_wrap_nxt;
        end

        w_busy_nxt      = (w_state_nxt == ST_RUN) || (w_state_nxt == ST_HOLD);
        w_cmd_ready_nxt = (w_state_nxt == ST_IDLE);
    end

    // State, latched command and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_term        <= '0;
            r_count       <= '0;
            r_passes_left <= '0;
            r_wrap        <= 1'b0;
            r_done        <= 1'b0;
            r_busy        <= 1'b0;
            r_cmd_ready   <= 1'b1;
        end else begin
            r_state       <= w_state_nxt;
            r_term        <= w_term_nxt;
            r_count       <= w_count_nxt;
            r_passes_left <= w_passes_nxt;
            r_wrap        <= w_wrap_nxt;
            r_done        <= w_done_nxt;
            r_busy        <= w_busy_nxt;
            r_cmd_ready   <= w_cmd_ready_nxt;
        end
    end

    assign bus.count       = r_count;
    assign bus.wrap        = r_wrap;
    assign bus.done        = r_done;
    assign bus.busy        = r_busy;
    assign bus.cmd_ready   = r_cmd_ready;
    assign bus.passes_left = r_passes_left;

endmodule

// File: tb/tb_mod16_count_ctrl.sv
// tb_mod16_count_ctrl: directed scoreboard bench for mod16_count_ctrl.
module tb_mod16_count_ctrl;

`ifdef MOD16_CTRL_HOLD_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    typedef struct {
        logic [3:0] count;
        logic       wrap;
        logic       done;
        logic       busy;
        logic       ready;
        logic [3:0] pl;
        string      tag;
    } exp_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    exp_t exp_q[$];

    mod16_count_ctrl_if #(.CW(4), .PW(4)) bus ();

    mod16_count_ctrl #(.CW(4), .PW(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input int c, input bit w, input bit d, input bit b,
                        input bit r, input int pl, input string tag);
        exp_t x;
        x.count = 4'(c);
        x.wrap  = w;
        x.done  = d;
        x.busy  = b;
        x.ready = r;
        x.pl    = 4'(pl);
        x.tag   = tag;
        exp_q.push_back(x);
    endtask

    task automatic step();
        exp_t x;
        @(posedge clk);
        #1;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty observed=none expected=entry");
        end else begin
            x = exp_q.pop_front();
            assert ({bus.count, bus.wrap, bus.done, bus.busy, bus.cmd_ready, bus.passes_left} ===
                    {x.count, x.wrap, x.done, x.busy, x.ready, x.pl})
            else begin
                bad++;
                $error("FAIL %s observed cnt=%0d wrap=%b done=%b busy=%b rdy=%b pl=%0d expected cnt=%0d wrap=%b done=%b busy=%b rdy=%b pl=%0d",
                       x.tag, bus.count, bus.wrap, bus.done, bus.busy, bus.cmd_ready, bus.passes_left,
                       x.count, x.wrap, x.done, x.busy, x.ready, x.pl);
            end
        end
    endtask

    // Full run: accept, count until done, then one cycle back to IDLE.
    // vld_at pulses a stray command at that run edge; hold is raised for
    // hold_len edges once the run reaches progress hold_at.
    task automatic run_cmd(input int term, input int np, input int vld_at,
                           input int hold_at, input int hold_len);
        int  p;
        int  e;
        int  held;
        int  tot;
        bit  hold_now;
        tot = np * (term + 1);
        bus.cmd_valid  = 1'b1;
        bus.cmd_term   = 4'(term);
        bus.cmd_passes = 4'(np);
        push(0, 1'b0, 1'b0, np != 0, 1'b0, np, "accept");
        step();
        bus.cmd_valid = 1'b0;
        if (np == 0) begin
            push(0, 1'b0, 1'b1, 1'b0, 1'b0, 0, "p0_done");
            step();
        end else begin
            p    = 0;
            e    = 0;
            held = 0;
            while (p < tot) begin
                e++;
                hold_now       = (p == hold_at) && (held < hold_len);
                bus.hold       = hold_now;
                bus.cmd_valid  = (e == vld_at);
                bus.cmd_term   = 4'(~term);
                bus.cmd_passes = 4'd9;
                if (hold_now) held++;
                if (hold_now && HOLD_EN) begin
                    push(p % (term + 1), 1'b0, 1'b0, 1'b1, 1'b0, np - p / (term + 1), "hold");
                end else begin
                    p++;
                    push(p % (term + 1), (p % (term + 1)) == 0, p == tot, p != tot, 1'b0,
                         np - p / (term + 1), "run");
                end
                step();
            end
            bus.hold      = 1'b0;
            bus.cmd_valid = 1'b0;
        end
        push(0, 1'b0, 1'b0, 1'b0, 1'b1, 0, "back_idle");
        step();
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        reset          = 1'b0;
        bus.cmd_valid  = 1'b0;
        bus.cmd_term   = 4'd0;
        bus.cmd_passes = 4'd0;
        bus.abort      = 1'b0;
        bus.hold       = 1'b0;

        // Power-on reset for two edges.
        push(0, 1'b0, 1'b0, 1'b0, 1'b1, 0, "reset0");
        step();
        push(0, 1'b0, 1'b0, 1'b0, 1'b1, 0, "reset1");
        step();
        reset = 1'b1;
        push(0, 1'b0, 1'b0, 1'b0, 1'b1, 0, "idle_after_reset");
        step();

        // Reset mid-run: term=7, P=2.
        bus.cmd_valid  = 1'b1;
        bus.cmd_term   = 4'd7;
        bus.cmd_passes = 4'd2;
        push(0, 1'b0, 1'b0, 1'b1, 1'b0, 2, "rst_accept");
        step();
        bus.cmd_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            push(k, 1'b0, 1'b0, 1'b1, 1'b0, 2, "rst_run");
            step();
        end
        reset = 1'b0;
        push(0, 1'b0, 1'b0, 1'b0, 1'b1, 0, "midrun_reset0");
        step();
        push(0, 1'b0, 1'b0, 1'b0, 1'b1, 0, "midrun_reset1");
        step();
        reset = 1'b1;
        push(0, 1'b0, 1'b0, 1'b0, 1'b1, 0, "post_reset_idle");
        step();

        // Full-range term, single pass.
        run_cmd(15, 1, -1, -1, 0);
        // Three short passes with a stray command mid-run.
        run_cmd(3, 3, 5, -1, 0);
        // term=0: every run edge wraps.
        run_cmd(0, 2, -1, -1, 0);
        // Zero passes: done one edge after accept, no wrap.
        run_cmd(0, 0, -1, -1, 0);
        run_cmd(5, 0, -1, -1, 0);

        // Abort at count=5 of pass 1: term=9, P=2.
        bus.cmd_valid  = 1'b1;
        bus.cmd_term   = 4'd9;
        bus.cmd_passes = 4'd2;
        push(0, 1'b0, 1'b0, 1'b1, 1'b0, 2, "abort_accept");
        step();
        bus.cmd_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            push(k, 1'b0, 1'b0, 1'b1, 1'b0, 2, "abort_run");
            step();
        end
        bus.abort = 1'b1;
        push(0, 1'b0, 1'b0, 1'b0, 1'b1, 0, "abort_idle");
        step();
        bus.abort = 1'b0;
        push(0, 1'b0, 1'b0, 1'b0, 1'b1, 0, "abort_no_done");
        step();

        // Hold for three edges at count=2: term=5, P=1.
        run_cmd(5, 1, -1, 2, 3);

        // Back-to-back after a hold run.
        run_cmd(2, 2, -1, -1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
